// File: rtl/cpu_io_host.sv
// cpu_io_host: host-side end of the CPU I/O port pair: input FIFO toward CPUIn,
// change-detect capture of CPUOut into an output FIFO, and a PC-stall halt detector.
module cpu_io_host #(
    parameter int WIDTH        = 32,
    parameter int IN_DEPTH     = 8,
    parameter int OUT_DEPTH    = 8,
    parameter int STALL_CYCLES = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] HostInData,
    input  logic             HostInValid,
    output logic             HostInReady,
    output logic [WIDTH-1:0] CPUIn,
    output logic             CPUInEmpty,
    input  logic             CPUInTake,
    input  logic [WIDTH-1:0] CPUOut,
    input  logic [WIDTH-1:0] PcCurrent,
    output logic [WIDTH-1:0] HostOutData,
    output logic             HostOutValid,
    input  logic             HostOutReady,
    output logic             OutOverflow,
    output logic             Halted
);
    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int SW  = $clog2(STALL_CYCLES + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_CYCLES);

    typedef enum logic [1:0] {INIT, RUN, HALTED} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    stall_q, stall_d;
    logic [WIDTH-1:0] prev_pc_q, prev_out_q;
    logic             ovf_q;

    logic [WIDTH-1:0] in_mem_q [IN_DEPTH];
    logic [IAW-1:0]   in_wr_q, in_rd_q;
    logic [IAW:0]     in_cnt_q;
    logic [WIDTH-1:0] out_mem_q [OUT_DEPTH];
    logic [OAW-1:0]   out_wr_q, out_rd_q;
    logic [OAW:0]     out_cnt_q;

    logic in_full, in_empty, in_push, in_pop;
    logic out_full, out_empty, out_push, out_pop, capture, drop;

    assign in_full   = in_cnt_q == (IAW+1)'(IN_DEPTH);
    assign in_empty  = in_cnt_q == '0;
    assign out_full  = out_cnt_q == (OAW+1)'(OUT_DEPTH);
    assign out_empty = out_cnt_q == '0;

    // Host pushes are only accepted once the detector is running; INIT and HALTED refuse them.
    assign HostInReady = (state_q == RUN) && !in_full;
    assign in_push     = HostInValid && HostInReady;
    assign in_pop      = CPUInTake && !in_empty;
    assign out_pop     = HostOutReady && !out_empty;
    assign capture     = (state_q == RUN) && (CPUOut != prev_out_q);
    assign out_push    = capture && (!out_full || out_pop);
    assign drop        = capture && out_full && !out_pop;

    assign CPUIn        = in_empty ? '0 : in_mem_q[in_rd_q];
    assign CPUInEmpty   = in_empty;
    assign HostOutData  = out_empty ? '0 : out_mem_q[out_rd_q];
    assign HostOutValid = !out_empty;
    assign OutOverflow  = ovf_q;
    assign Halted       = state_q == HALTED;

    // Next state: INIT always advances; RUN counts repeated PCs and halts at the threshold.
    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        if (state_q == INIT) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            stall_d = (PcCurrent != prev_pc_q) ? '0 :
                      (stall_q == STALL_MAX) ? stall_q : stall_q + SW'(1);
            if (stall_d == STALL_MAX) state_d = HALTED;
        end
    end

    // Control state, history registers, FIFO pointers/counts and the sticky overflow flag.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q    <= INIT;
            stall_q    <= '0;
            prev_pc_q  <= '0;
            prev_out_q <= '0;
            ovf_q      <= 1'b0;
            in_wr_q    <= '0;
            in_rd_q    <= '0;
            in_cnt_q   <= '0;
            out_wr_q   <= '0;
            out_rd_q   <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            prev_pc_q  <= PcCurrent;
            prev_out_q <= CPUOut;
            ovf_q      <= ovf_q || drop;
            in_wr_q    <= in_wr_q + IAW'(in_push);
            in_rd_q    <= in_rd_q + IAW'(in_pop);
            in_cnt_q   <= in_cnt_q + (IAW+1)'(in_push) - (IAW+1)'(in_pop);
            out_wr_q   <= out_wr_q + OAW'(out_push);
            out_rd_q   <= out_rd_q + OAW'(out_pop);
            out_cnt_q  <= out_cnt_q + (OAW+1)'(out_push) - (OAW+1)'(out_pop);
        end
    end

    // FIFO storage needs no reset: empty FIFOs mask their heads to zero.
    always_ff @(posedge CLK) begin
        if (in_push) in_mem_q[in_wr_q] <= HostInData;
        if (out_push) out_mem_q[out_wr_q] <= CPUOut;
    end
endmodule

// File: tb/tb_cpu_io_host.sv
// tb_cpu_io_host: directed and randomized checks of cpu_io_host against a queue-based model.
module tb_cpu_io_host;
    localparam int W = 32;
    localparam int D = 8;
    localparam int S = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] host_data, cpu_in, cpu_out, pc, host_out_data;
    logic         host_valid, host_in_ready, cpu_in_empty, cpu_take;
    logic         host_out_valid, host_out_ready, out_overflow, halted;

    always #5 clk = ~clk;

    cpu_io_host #(.WIDTH(W), .IN_DEPTH(D), .OUT_DEPTH(D), .STALL_CYCLES(S)) dut (
        .CLK(clk), .Reset(rst_n),
        .HostInData(host_data), .HostInValid(host_valid), .HostInReady(host_in_ready),
        .CPUIn(cpu_in), .CPUInEmpty(cpu_in_empty), .CPUInTake(cpu_take),
        .CPUOut(cpu_out), .PcCurrent(pc),
        .HostOutData(host_out_data), .HostOutValid(host_out_valid), .HostOutReady(host_out_ready),
        .OutOverflow(out_overflow), .Halted(halted)
    );

    int comps = 0;
    int fails = 0;

    logic [W-1:0] in_q[$];
    logic [W-1:0] out_q[$];
    bit           started, m_halted, m_ovf;
    logic [W-1:0] prev_out, prev_pc;
    int           same_cnt;
    int           pc_mode;

    task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        comps++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        started  = 0;
        m_halted = 0;
        m_ovf    = 0;
        prev_out = '0;
        prev_pc  = '0;
        same_cnt = 0;
    endtask

    task automatic check_all(string tag);
        chk({tag, "_cpuin"}, cpu_in, in_q.size() > 0 ? in_q[0] : '0);
        chk({tag, "_inempty"}, cpu_in_empty, in_q.size() == 0);
        chk({tag, "_inready"}, host_in_ready, started && !m_halted && in_q.size() < D);
        chk({tag, "_outdata"}, host_out_data, out_q.size() > 0 ? out_q[0] : '0);
        chk({tag, "_outvalid"}, host_out_valid, out_q.size() > 0);
        chk({tag, "_ovf"}, out_overflow, m_ovf);
        chk({tag, "_halted"}, halted, m_halted);
    endtask

    task automatic cyc(string tag);
        bit rdy, take, push, opop, chg;
        if (pc_mode == 1) pc = pc + 4;
        if (pc_mode == 2) pc = ($urandom_range(0, 60) == 0) ? pc : pc + 4;
        rdy  = started && !m_halted && in_q.size() < D;
        take = cpu_take && in_q.size() > 0;
        push = host_valid && rdy;
        opop = host_out_ready && out_q.size() > 0;
        chg  = started && !m_halted && cpu_out != prev_out;
        if (take) void'(in_q.pop_front());
        if (push) in_q.push_back(host_data);
        if (opop) void'(out_q.pop_front());
        if (chg) begin
            if (out_q.size() < D) out_q.push_back(cpu_out);
            else m_ovf = 1;
        end
        if (!started) started = 1;
        else if (!m_halted) begin
            same_cnt = (pc == prev_pc) ? same_cnt + 1 : 0;
            if (same_cnt >= S) m_halted = 1;
        end
        prev_pc  = pc;
        prev_out = cpu_out;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic rst_task(string tag);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        host_data = '0; host_valid = 0; cpu_take = 0; cpu_out = '0; pc = '0; host_out_ready = 0;
        pc_mode = 0;
        model_reset();
        // 1: reset holds outputs regardless of inputs, then INIT for one cycle
        for (int i = 0; i < 4; i++) begin
            host_data = $urandom; host_valid = 1'($urandom); cpu_take = 1'($urandom);
            cpu_out = $urandom; pc = $urandom; host_out_ready = 1'($urandom);
            #3;
            check_all("t1_rst");
        end
        host_data = '0; host_valid = 0; cpu_take = 0; cpu_out = '0; pc = 100; host_out_ready = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t1_init_ready", host_in_ready, 0);
        pc_mode = 1;
        cyc("t1_init");
        chk("t1_run_ready", host_in_ready, 1);
        // 2: push 5,7,9 then take each
        host_valid = 1;
        host_data = 5; cyc("t2_push");
        host_data = 7; cyc("t2_push");
        host_data = 9; cyc("t2_push");
        host_valid = 0;
        chk("t2_head5", cpu_in, 5);
        cpu_take = 1;
        cyc("t2_take"); chk("t2_head7", cpu_in, 7);
        cyc("t2_take"); chk("t2_head9", cpu_in, 9);
        cyc("t2_take"); chk("t2_head0", cpu_in, 0); chk("t2_empty", cpu_in_empty, 1);
        cyc("t2_take_empty");
        cpu_take = 0;
        // 3: fill, then push+take while full
        host_valid = 1;
        for (int i = 0; i < D; i++) begin
            host_data = $urandom;
            cyc("t3_fill");
        end
        chk("t3_full_ready", host_in_ready, 0);
        host_data = 32'hdead; cpu_take = 1;
        cyc("t3_push_take");
        chk("t3_ready_after", host_in_ready, 1);
        host_valid = 0;
        for (int i = 0; i < D - 1; i++) cyc("t3_drain");
        chk("t3_drained", cpu_in_empty, 1);
        cpu_take = 0;
        // 4: change-detect capture 0->3->3->4
        cpu_out = 3; cyc("t4_cap");
        cyc("t4_same");
        cpu_out = 4; cyc("t4_cap");
        chk("t4_head", host_out_data, 3);
        host_out_ready = 1;
        cyc("t4_pop"); chk("t4_second", host_out_data, 4);
        cyc("t4_pop"); chk("t4_empty", host_out_valid, 0);
        host_out_ready = 0;
        // 5: overflow on the ninth distinct value
        for (int i = 0; i < D + 1; i++) begin
            cpu_out = 100 + i;
            cyc("t5_fill");
        end
        chk("t5_ovf", out_overflow, 1);
        chk("t5_head", host_out_data, 100);
        host_out_ready = 1;
        cyc("t5_pop"); chk("t5_next", host_out_data, 101);
        for (int i = 0; i < D - 1; i++) cyc("t5_drain");
        chk("t5_drained", host_out_valid, 0);
        host_out_ready = 0;
        // 6: PC stall halts; captures and pushes then refused
        pc_mode = 0;
        pc = 100;
        rst_task("t6_rst");
        cyc("t6_init");
        pc = 0; cyc("t6_pc");
        pc = 4; cyc("t6_pc");
        pc = 8; cyc("t6_pc");
        chk("t6_not_halted", halted, 0);
        pc = 8; cyc("t6_pc");
        chk("t6_halted", halted, 1);
        cpu_out = cpu_out + 1; host_valid = 1; host_data = 77;
        cyc("t6_halted_io");
        chk("t6_nocap", host_out_valid, 0);
        chk("t6_ready", host_in_ready, 0);
        host_valid = 0;
        // randomized traffic with occasional resets and PC stalls
        for (int r = 0; r < 4; r++) begin
            rst_task("rnd_rst");
            pc_mode = 2;
            for (int i = 0; i < 120; i++) begin
                host_valid     = $urandom_range(0, 2) != 0;
                host_data      = $urandom;
                cpu_take       = $urandom_range(0, r + 1) == 0;
                host_out_ready = $urandom_range(0, 3 - r) == 0;
                cpu_out        = $urandom_range(0, 4);
                cyc("rnd");
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
        $finish;
    end
endmodule
